// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter.
// One add-3/shift iteration per clock, start/busy/done handshake.
// Optional feature macro: LEAD_ZERO_BLANK_EN (leading-zero blanking mask on blank;
// when undefined, blank is tied to 0).
module bin_to_bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic [DIGITS-1:0]   blank
);

    localparam int BW    = 4 * DIGITS;
    localparam int TW    = BW + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   bin_work_q, bin_work_d;
    logic [BW-1:0]      bcd_work_q, bcd_work_d;
    logic               sticky_q, sticky_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [BW-1:0]      bcd_adj;
    logic [TW-1:0]      shifted;
    logic               shift_out;

    // Add 3 to every nibble >= 5 so the following shift carries correctly into the next digit.
    function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign bcd_adj   = add3_all(bcd_work_q);
    assign shifted   = {bcd_adj, bin_work_q} << 1;
    // A carry out of the top digit means the result no longer fits in DIGITS digits.
    assign shift_out = bcd_adj[BW-1];

`ifdef LEAD_ZERO_BLANK_EN
    logic [DIGITS-1:0]  blank_q, blank_d;

    // Digit i (i >= 1) is blanked when it and every higher digit are zero; digit 0 always shows.
    function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [BW-1:0] v);
        logic [DIGITS-1:0] m;
        logic              z;
        m = '0;
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z    = z & (v[4*i +: 4] == 4'd0);
            m[i] = z;
        end
        return m;
    endfunction
`endif

    // Next-state, datapath iteration and result capture for the IDLE/SHIFT FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_work_d = bin_work_q;
        bcd_work_d = bcd_work_q;
        sticky_d   = sticky_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
`ifdef LEAD_ZERO_BLANK_EN
        blank_d    = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_work_d = bin;
                    bcd_work_d = '0;
                    sticky_d   = 1'b0;
                    cnt_d      = CNT_W'(WIDTH);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bin_work_d = shifted[WIDTH-1:0];
                bcd_work_d = shifted[TW-1:WIDTH];
                sticky_d   = sticky_q | shift_out;
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Last iteration: publish the freshly shifted value, not the stale working copy.
                    bcd_d   = shifted[TW-1:WIDTH];
                    ovf_d   = sticky_q | shift_out;
`ifdef LEAD_ZERO_BLANK_EN
                    blank_d = lead_zero_mask(shifted[TW-1:WIDTH]);
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, working and output registers; async reset returns everything to the idle, zeroed state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bin_work_q <= '0;
            bcd_work_q <= '0;
            sticky_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_work_q <= bin_work_d;
            bcd_work_q <= bcd_work_d;
            sticky_q   <= sticky_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    // Blanking mask register, updated together with bcd on the done edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end
    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq: default 14-bit/5-digit instance plus an
// undersized 8-bit/2-digit instance for the truncation case.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        ovf;
    logic [4:0]  blank;

    logic        s_start;
    logic [7:0]  s_bin;
    logic        s_busy;
    logic        s_done;
    logic [7:0]  s_bcd;
    logic        s_ovf;
    logic [1:0]  s_blank;

    int n_cmp;
    int n_fail;

    bin_to_bcd_seq #(.WIDTH(14), .DIGITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf),
        .blank (blank)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s_start),
        .bin   (s_bin),
        .busy  (s_busy),
        .done  (s_done),
        .bcd   (s_bcd),
        .ovf   (s_ovf),
        .blank (s_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until done (bounded); n returns the number of steps taken.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    // Start a conversion on the big instance; optionally pulse start and scramble bin mid-run.
    task automatic convert(input string tag, input logic [13:0] v, input logic [19:0] exp_bcd,
                           input logic exp_ovf, input logic [4:0] exp_blank, input bit glitch);
        int nb;
        bin   = v;
        start = 1'b1;
        step();
        start = 1'b0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) break;
            if (busy === 1'b1) nb++;
            if (glitch && i == 5) begin
                start = 1'b1;
                bin   = 14'h2AAA;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_cycles"}, nb, 32'd14);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({tag, "_bcd"}, {12'd0, bcd}, {12'd0, exp_bcd});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        chk({tag, "_blank"}, {27'd0, blank}, {27'd0, exp_blank});
        step();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_bcd_hold"}, {12'd0, bcd}, {12'd0, exp_bcd});
    endtask

    // Conversion on the undersized 8-bit/2-digit instance.
    task automatic convert_s(input string tag, input logic [7:0] v, input logic [7:0] exp_bcd,
                             input logic exp_ovf, input logic [1:0] exp_blank);
        int n;
        s_bin   = v;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        n = 0;
        while (s_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n, 32'd8);
        chk({tag, "_bcd"}, {24'd0, s_bcd}, {24'd0, exp_bcd});
        chk({tag, "_ovf"}, {31'd0, s_ovf}, {31'd0, exp_ovf});
        chk({tag, "_blank"}, {30'd0, s_blank}, {30'd0, exp_blank});
        step();
    endtask

    initial begin
        int  n;
        int  n2;
        bit  saw_done;
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        bin     = '0;
        s_start = 1'b0;
        s_bin   = '0;

        // Reset held with start toggling: everything stays zero.
        for (int i = 0; i < 4; i++) begin
            start = (i % 2 == 0);
            bin   = 14'd1234;
            step();
            chk("rst_ctrl", {29'd0, busy, done, ovf}, 32'd0);
            chk("rst_bcd", {12'd0, bcd}, 32'd0);
            chk("rst_blank", {27'd0, blank}, 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);

`ifdef LEAD_ZERO_BLANK_EN
        convert("c9999", 14'd9999, 20'h09999, 1'b0, 5'b10000, 1'b0);
        convert("c0", 14'd0, 20'h00000, 1'b0, 5'b11110, 1'b0);
        convert("c16383", 14'd16383, 20'h16383, 1'b0, 5'b00000, 1'b0);
        convert("c700g", 14'd700, 20'h00700, 1'b0, 5'b11000, 1'b1);
`else
        convert("c9999", 14'd9999, 20'h09999, 1'b0, 5'b00000, 1'b0);
        convert("c0", 14'd0, 20'h00000, 1'b0, 5'b00000, 1'b0);
        convert("c16383", 14'd16383, 20'h16383, 1'b0, 5'b00000, 1'b0);
        convert("c700g", 14'd700, 20'h00700, 1'b0, 5'b00000, 1'b1);
`endif

        // Back-to-back with start held high.
        bin   = 14'd1234;
        start = 1'b1;
        step();
        wait_done(n);
        chk("b2b_lat", n, 32'd14);
        chk("b2b_bcd1", {12'd0, bcd}, 32'h01234);
        bin = 14'd42;
        step();
        chk("b2b_restart_busy", {31'd0, busy}, 32'd1);
        wait_done(n2);
        chk("b2b_period", n2 + 1, 32'd15);
        chk("b2b_bcd2", {12'd0, bcd}, 32'h00042);
        start = 1'b0;
        step();
        chk("b2b_stop", {30'd0, busy, done}, 32'd0);

        // Reset during the 7th SHIFT cycle of a conversion.
        bin   = 14'd5000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {29'd0, busy, done, ovf}, 32'd0);
        chk("mid_rst_bcd", {12'd0, bcd}, 32'd0);
        step();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("mid_no_done", {31'd0, saw_done}, 32'd0);
        chk("mid_bcd_zero", {12'd0, bcd}, 32'd0);
`ifdef LEAD_ZERO_BLANK_EN
        convert("c5000", 14'd5000, 20'h05000, 1'b0, 5'b10000, 1'b0);
`else
        convert("c5000", 14'd5000, 20'h05000, 1'b0, 5'b00000, 1'b0);
`endif

        // Undersized instance: truncation and sticky overflow clear.
        convert_s("s255", 8'd255, 8'h55, 1'b1, 2'b00);
        convert_s("s99", 8'd99, 8'h99, 1'b0, 2'b00);
`ifdef LEAD_ZERO_BLANK_EN
        convert_s("s7", 8'd7, 8'h07, 1'b0, 2'b10);
`else
        convert_s("s7", 8'd7, 8'h07, 1'b0, 2'b00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
